// File: rtl/sim_ram_pkg.sv
// Shared constants for the simulation RAM front end.
// Also provides the byte-strobe to bit-mask expansion used by the RAMHelper.
package sim_ram_pkg;

    localparam int          DATA_W        = 64;
    localparam int          WORD_SHIFT    = 3;
    localparam logic [63:0] DEF_BASE_ADDR = 64'h8000_0000;
    localparam logic [63:0] DEF_MEM_BYTES = 64'h0800_0000;

    function automatic logic [DATA_W-1:0] strb_to_mask(input logic [DATA_W/8-1:0] strb);
        logic [DATA_W-1:0] m;
        m = '0;
        for (int k = 0; k < DATA_W/8; k++) begin
            m[8*k +: 8] = {8{strb[k]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/sim_ram_arbiter_if.sv
// Multi-channel request/response bus into the RAM arbiter.
// Requesters use the master modport; the arbiter uses the slave modport.
interface sim_ram_arbiter_if #(
    parameter int NUM_CH = 2
);
    import sim_ram_pkg::*;

    logic [NUM_CH-1:0]             req_valid;
    logic [NUM_CH-1:0]             req_ready;
    logic [NUM_CH-1:0]             req_wen;
    logic [NUM_CH-1:0][DATA_W-1:0] req_addr;
    logic [NUM_CH-1:0][DATA_W-1:0] req_wdata;
    logic [NUM_CH-1:0][7:0]        req_wstrb;
    logic [NUM_CH-1:0]             resp_valid;
    logic [NUM_CH-1:0][DATA_W-1:0] resp_rdata;
    logic [NUM_CH-1:0]             resp_err;

    modport master (
        output req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_wen, req_addr, req_wdata, req_wstrb,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
// Generic over N so it can be reused for other shared buses.
module rr_arbiter #(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    always_comb begin
        int c;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        c   = 0;
        for (int k = 0; k < N; k++) begin
            if (!any) begin
                c = (int'(ptr) + k) % N;
                if (req[c]) begin
                    any    = 1'b1;
                    gnt[c] = 1'b1;
                    idx    = IW'(c);
                end
            end
        end
    end

endmodule

// File: rtl/sim_ram_arbiter.sv
// Round-robin front end multiplexing NUM_CH channels onto the RAMHelper port.
// RAM side is combinational from arbitration; responses are registered one cycle later.
module sim_ram_arbiter
    import sim_ram_pkg::*;
#(
    parameter int          NUM_CH    = 2,
    parameter logic [63:0] BASE_ADDR = DEF_BASE_ADDR,
    parameter logic [63:0] MEM_BYTES = DEF_MEM_BYTES
) (
    input  logic              clock,
    input  logic              reset,
    sim_ram_arbiter_if.slave  bus,
    output logic              ram_ren,
    output logic [63:0]       ram_ridx,
    input  logic [63:0]       ram_rdata,
    output logic              ram_wen,
    output logic [63:0]       ram_widx,
    output logic [63:0]       ram_wdata,
    output logic [63:0]       ram_wmask
);

    localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [IW-1:0]     ptr;
    logic [IW-1:0]     gidx;
    logic [NUM_CH-1:0] gnt;
    logic              any;
    logic              fire;
    logic              in_win;
    logic              is_wr;
    logic [63:0]       addr;
    logic [63:0]       off;

    rr_arbiter #(.N(NUM_CH)) u_arb (
        .req (bus.req_valid),
        .ptr (ptr),
        .gnt (gnt),
        .idx (gidx),
        .any (any)
    );

    // Reset suppresses the grant so a handshake in a reset cycle never happens.
    assign fire  = any & ~reset;
    assign addr  = bus.req_addr[gidx];
    assign is_wr = bus.req_wen[gidx];
    assign off   = addr - BASE_ADDR;
    // The lower-bound test keeps a wrapped subtraction from looking in-window.
    assign in_win = (addr >= BASE_ADDR) && (off < MEM_BYTES);

    assign bus.req_ready = fire ? gnt : '0;

    assign ram_ren   = fire & in_win & ~is_wr;
    assign ram_wen   = fire & in_win & is_wr;
    assign ram_ridx  = ram_ren ? (off >> WORD_SHIFT) : '0;
    assign ram_widx  = ram_wen ? (off >> WORD_SHIFT) : '0;
    assign ram_wdata = ram_wen ? bus.req_wdata[gidx] : '0;
    assign ram_wmask = ram_wen ? strb_to_mask(bus.req_wstrb[gidx]) : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr            <= '0;
            bus.resp_valid <= '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= '0;
        end else begin
            bus.resp_valid <= fire ? gnt : '0;
            bus.resp_rdata <= '0;
            bus.resp_err   <= '0;
            if (fire) begin
                bus.resp_rdata[gidx] <= ram_ren ? ram_rdata : '0;
                bus.resp_err[gidx]   <= ~in_win;
                ptr <= (gidx == IW'(NUM_CH - 1)) ? '0 : gidx + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sim_ram_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// transaction-level model (round-robin pick, window test, word memory).
module tb_sim_ram_arbiter;
    import sim_ram_pkg::*;

    localparam int          N    = 3;
    localparam logic [63:0] BASE = 64'h8000_0000;
    localparam logic [63:0] MEMB = 64'h0800_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ram_ren, ram_wen;
    logic [63:0] ram_ridx, ram_rdata, ram_widx, ram_wdata, ram_wmask;

    // RAM stand-in: 256 words, mirrored across the window.
    logic [63:0] mem [256];
    assign ram_rdata = mem[ram_ridx[7:0]];

    sim_ram_arbiter_if #(.NUM_CH(N)) bus ();

    sim_ram_arbiter #(.NUM_CH(N), .BASE_ADDR(BASE), .MEM_BYTES(MEMB)) dut (
        .clock     (clock),
        .reset     (reset),
        .bus       (bus),
        .ram_ren   (ram_ren),
        .ram_ridx  (ram_ridx),
        .ram_rdata (ram_rdata),
        .ram_wen   (ram_wen),
        .ram_widx  (ram_widx),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask)
    );

    always #5 clock = ~clock;

    logic [63:0]          ref_mem [256];
    int                   mptr;
    int                   last_g;
    logic [N-1:0]         exp_valid, exp_err;
    logic [N-1:0][63:0]   exp_rdata;
    int                   n_chk = 0;
    int                   n_err = 0;

    task automatic chk(input string tag, input logic [191:0] got, input logic [191:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int c, input logic v, input logic w, input logic [63:0] a,
                           input logic [63:0] d, input logic [7:0] s);
        bus.req_valid[c] = v;
        bus.req_wen[c]   = w;
        bus.req_addr[c]  = a;
        bus.req_wdata[c] = d;
        bus.req_wstrb[c] = s;
    endtask

    task automatic idle_all();
        for (int c = 0; c < N; c++) set_req(c, 1'b0, 1'b0, 64'd0, 64'd0, 8'd0);
    endtask

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 9))
            0: begin
                case ($urandom_range(0, 4))
                    0:       a = BASE - 64'd8;
                    1:       a = BASE + MEMB;
                    2:       a = 64'd0;
                    3:       a = 64'hFFFF_FFFF_FFFF_FFF8;
                    default: a = BASE + MEMB + 64'd8;
                endcase
            end
            1:       a = BASE + MEMB - 64'd8 + 64'($urandom_range(0, 7));
            default: a = BASE + 64'($urandom_range(0, 255)) * 64'd8 + 64'($urandom_range(0, 7));
        endcase
        return a;
    endfunction

    task automatic rand_req(input int c);
        set_req(c, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), rand_addr(),
                {$urandom, $urandom}, 8'($urandom));
    endtask

    // One cycle: check DUT at negedge against the model, then advance the model.
    task automatic step();
        int           g;
        logic [63:0]  a, idx, mask;
        logic         inwin, wr;
        logic         e_ren, e_wen;
        logic [63:0]  e_ridx, e_widx, e_wdata, e_wmask;
        logic [N-1:0] e_rdy;
        @(negedge clock);
        g = -1;
        if (!reset) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (mptr + k) % N;
                if (g < 0 && bus.req_valid[c]) g = c;
            end
        end
        e_ren = 1'b0; e_wen = 1'b0; e_ridx = '0; e_widx = '0; e_wdata = '0; e_wmask = '0;
        e_rdy = '0; inwin = 1'b0; wr = 1'b0; a = '0; idx = '0; mask = '0;
        if (g >= 0) begin
            e_rdy[g] = 1'b1;
            a     = bus.req_addr[g];
            wr    = bus.req_wen[g];
            inwin = (a >= BASE) && (a < BASE + MEMB);
            idx   = (a - BASE) / 64'd8;
            for (int b = 0; b < 8; b++) mask[8*b +: 8] = bus.req_wstrb[g][b] ? 8'hFF : 8'h00;
            if (inwin && !wr) begin e_ren = 1'b1; e_ridx = idx; end
            if (inwin && wr) begin
                e_wen = 1'b1; e_widx = idx; e_wdata = bus.req_wdata[g]; e_wmask = mask;
            end
        end
        chk("req_ready",  192'(bus.req_ready),  192'(e_rdy));
        chk("ram_en",     192'({ram_ren, ram_wen}), 192'({e_ren, e_wen}));
        chk("ram_ridx",   192'(ram_ridx),  192'(e_ridx));
        chk("ram_widx",   192'(ram_widx),  192'(e_widx));
        chk("ram_wdata",  192'(ram_wdata), 192'(e_wdata));
        chk("ram_wmask",  192'(ram_wmask), 192'(e_wmask));
        chk("resp_valid", 192'(bus.resp_valid), 192'(exp_valid));
        chk("resp_rdata", 192'(bus.resp_rdata), 192'(exp_rdata));
        chk("resp_err",   192'(bus.resp_err),   192'(exp_err));
        exp_valid = '0; exp_rdata = '0; exp_err = '0;
        if (g >= 0) begin
            exp_valid[g] = 1'b1;
            exp_err[g]   = !inwin;
            if (inwin && !wr) exp_rdata[g] = ref_mem[idx[7:0]];
            if (inwin && wr)
                ref_mem[idx[7:0]] = (ref_mem[idx[7:0]] & ~mask) | (bus.req_wdata[g] & mask);
            mptr = (g + 1) % N;
        end
        if (reset) mptr = 0;
        last_g = g;
        if (ram_wen) mem[ram_widx[7:0]] = (mem[ram_widx[7:0]] & ~ram_wmask) | (ram_wdata & ram_wmask);
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [N-1:0] e;
        for (int i = 0; i < 256; i++) begin
            mem[i]     = {$urandom, $urandom};
            ref_mem[i] = mem[i];
        end
        mptr = 0; last_g = -1;
        exp_valid = '0; exp_rdata = '0; exp_err = '0;
        idle_all();
        reset = 1'b1;
        @(posedge clock);
        #1;
        step();
        reset = 1'b0;
        chk("rst_resp_valid", 192'(bus.resp_valid), 192'(0));
        chk("rst_resp_rdata", 192'(bus.resp_rdata), 192'(0));

        // Single read on ch0
        mem[2] = 64'hDEAD_BEEF_0123_4567; ref_mem[2] = mem[2];
        set_req(0, 1'b1, 1'b0, 64'h8000_0010, 64'd0, 8'd0);
        #1;
        chk("t1_ren_ridx", 192'({ram_ren, ram_ridx}), 192'({1'b1, 64'd2}));
        step();
        idle_all();
        chk("t1_rvalid", 192'(bus.resp_valid), 192'(3'b001));
        chk("t1_rdata", 192'(bus.resp_rdata[0]), 192'(64'hDEAD_BEEF_0123_4567));
        step();

        // Masked write on ch1, then read-back
        mem[1] = 64'hAAAA_BBBB_CCCC_DDDD; ref_mem[1] = mem[1];
        set_req(1, 1'b1, 1'b1, 64'h8000_0008, 64'h1122_3344_5566_7788, 8'h0F);
        #1;
        chk("t2_widx", 192'(ram_widx), 192'(64'd1));
        chk("t2_wmask", 192'(ram_wmask), 192'(64'h0000_0000_FFFF_FFFF));
        step();
        set_req(1, 1'b1, 1'b0, 64'h8000_0008, 64'd0, 8'd0);
        chk("t2_wresp", 192'({bus.resp_valid, bus.resp_rdata[1]}), 192'({3'b010, 64'd0}));
        step();
        idle_all();
        chk("t2_readback", 192'(bus.resp_rdata[1]), 192'(64'hAAAA_BBBB_5566_7788));
        step();

        // Contention: all channels valid for 6 cycles starting from ptr 0
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int c = 0; c < N; c++) set_req(c, 1'b1, 1'b0, BASE + 64'(8 * c), 64'd0, 8'd0);
        for (int k = 0; k < 6; k++) begin
            #1;
            e = '0;
            e[k % N] = 1'b1;
            chk("t3_grant", 192'(bus.req_ready), 192'(e));
            step();
        end
        idle_all();
        step();

        // Out of window, below and above
        set_req(2, 1'b1, 1'b0, 64'h7FFF_FFF8, 64'd0, 8'd0);
        #1;
        chk("t4a_en", 192'({ram_ren, ram_wen}), 192'(0));
        step();
        chk("t4a_resp", 192'({bus.resp_err[2], bus.resp_rdata[2]}), 192'({1'b1, 64'd0}));
        set_req(2, 1'b1, 1'b1, 64'h8800_0000, 64'h0123_4567_89AB_CDEF, 8'hFF);
        #1;
        chk("t4b_en", 192'({ram_ren, ram_wen}), 192'(0));
        step();
        idle_all();
        chk("t4b_resp", 192'({bus.resp_err[2], bus.resp_rdata[2]}), 192'({1'b1, 64'd0}));
        step();

        // Back-to-back on ch0
        for (int k = 0; k < 4; k++) begin
            set_req(0, 1'b1, 1'b0, BASE + 64'h100 + 64'(8 * k), 64'd0, 8'd0);
            step();
            chk("t5_resp", 192'(bus.resp_valid), 192'(3'b001));
        end
        idle_all();
        step();
        chk("t5_quiet", 192'(bus.resp_valid), 192'(0));

        // Reset in a handshake cycle
        set_req(0, 1'b1, 1'b0, BASE, 64'd0, 8'd0);
        step();
        set_req(1, 1'b1, 1'b0, BASE + 64'd8, 64'd0, 8'd0);
        reset = 1'b1;
        #1;
        chk("t6_ready", 192'(bus.req_ready), 192'(0));
        chk("t6_en", 192'({ram_ren, ram_wen}), 192'(0));
        step();
        reset = 1'b0;
        chk("t6_resp", 192'(bus.resp_valid), 192'(0));
        set_req(2, 1'b1, 1'b0, BASE + 64'd16, 64'd0, 8'd0);
        #1;
        chk("t6_ptr", 192'(bus.req_ready), 192'(3'b001));
        step();
        idle_all();
        step();

        // Randomized traffic, requesters hold until granted
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int c = 0; c < N; c++) begin
                if (!bus.req_valid[c] || c == last_g) rand_req(c);
            end
            reset = ($urandom_range(0, 49) == 0);
            step();
        end
        reset = 1'b0;
        idle_all();
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
